bin2bcd_seq: RTL

Sequential double-dabble converter that turns an unsigned binary count (0–999 valid) into three BCD digits: `one`, `ten`, `hun`. It is the producer side of the seven-segment digit path. Its registered digit outputs feed the digit-select/scan mux directly, so the display never sees a partially converted value. A start/busy/done handshake lets the score, timer or volume logic request a conversion at any rate.

---
 rtl/bin2bcd_seq_pkg.sv | 15 +
 rtl/bin2bcd_seq_add3.sv | 16 +
 rtl/bin2bcd_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential
// binary-to-BCD converter.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_e;

  localparam int BCD_W = 4;
  localparam int unsigned MAX_DEC = 999;
  localparam logic [3*BCD_W-1:0] SAT_BCD = 12'h999;

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble nibble corrector:
// adds 3 to any digit of 5 or more.
module bcd_add3
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_W-1:0] nib_i,
  output logic [BCD_W-1:0] nib_o
);

  // per-nibble 4-bit add, no carry out
  always_comb begin
    nib_o = nib_i;
    if (nib_i >= 4'd5) nib_o = nib_i + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with a
// start/busy/done handshake and registered digits.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int IN_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IN_W-1:0] bin,
  output logic            busy,
  output logic            done,
  output logic [3:0]      one,
  output logic [3:0]      ten,
  output logic [3:0]      hun,
  output logic            ovf
);

  localparam int SCR_W = 3 * BCD_W;
  localparam int CNT_W = $clog2(IN_W + 1);

  state_e             state_q, state_d;
  logic [IN_W-1:0]    sr_q, sr_d;
  logic [SCR_W-1:0]   scr_q, scr_d;
  logic [SCR_W-1:0]   corr;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_f_q, ovf_f_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   one_q, one_d;
  logic [BCD_W-1:0]   ten_q, ten_d;
  logic [BCD_W-1:0]   hun_q, hun_d;
  logic               ovf_q, ovf_d;

  for (genvar g = 0; g < 3; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_i (scr_q[g*BCD_W +: BCD_W]),
      .nib_o (corr[g*BCD_W +: BCD_W])
    );
  end

  // next-state, datapath and output register inputs
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    ovf_f_d = ovf_f_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    one_d   = one_q;
    ten_d   = ten_q;
    hun_d   = hun_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = bin;
          scr_d   = '0;
          cnt_d   = CNT_W'(IN_W);
          busy_d  = 1'b1;
          ovf_f_d = {{(32-IN_W){1'b0}}, bin}
                    > MAX_DEC;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, sr_d} = {corr, sr_q} << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = LOAD;
      end
      LOAD: begin
        if (ovf_f_q) begin
          {hun_d, ten_d, one_d} = SAT_BCD;
        end else begin
          {hun_d, ten_d, one_d} = scr_q;
        end
        ovf_d   = ovf_f_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      ovf_f_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      one_q   <= '0;
      ten_q   <= '0;
      hun_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      ovf_f_q <= ovf_f_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      one_q   <= one_d;
      ten_q   <= ten_d;
      hun_q   <= hun_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign one  = one_q;
  assign ten  = ten_q;
  assign hun  = hun_q;
  assign ovf  = ovf_q;

endmodule
